vdp_cpu_port: RTL and testbench

- Parametrised CPU-side port interface for the TMS99xx-family video display processor (VDP).
- Decodes data-port and control-port accesses into the following:
  - the two-byte control latch,
  - register writes,
  - VRAM address setup,
  - auto-incrementing VRAM data access through a read-ahead buffer,
  - the status register with clear-on-read flags.
- Sits between the Z80 IO decode and the video renderer's VRAM port.
- Unlike the current inline port logic, it acts exactly once per IO access, supports addresses wider than 14 bits and has a VRAM request/acknowledge handshake with CPU wait.

---
 rtl/vdp_cpu_port.sv | 211 +++++++++++++++++++++
 tb/tb_vdp_cpu_port.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: CPU-side port of a TMS99xx-family VDP.
// Each Z80 IO access is decoded exactly once. The block owns:
//   - the two-byte control latch and the register file,
//   - the VRAM address with auto-increment,
//   - the read-ahead buffer and the VRAM request/ack handshake,
//   - the status register, whose flags clear when it is read.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   clk_en              CPU enable; IO strobes are sampled only when high
//   io_rd/io_wr         decoded IO strobes; port_sel 0=data, 1=control
//   cpu_din/cpu_dout    CPU data bus
//   wait_n              low while a data-side access waits on VRAM
//   vram_*              single-outstanding VRAM request/ack port
//   frame/coll/fifth_*  status event pulses from the renderer
//   regs                flattened register file, reg n at [8n+7:8n]
//   int_n               registered interrupt request (F & reg1 bit5)
module vdp_cpu_port #(
  parameter int ADDR_BITS = 14,
  parameter int NUM_REGS  = 8,
  parameter int HI_REG    = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic                  io_rd,
  input  logic                  io_wr,
  input  logic                  port_sel,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  wait_n,
  output logic [ADDR_BITS-1:0]  vram_addr,
  output logic [7:0]            vram_wdata,
  output logic                  vram_req,
  output logic                  vram_we,
  input  logic [7:0]            vram_rdata,
  input  logic                  vram_ack,
  input  logic                  frame_pulse,
  input  logic                  coll_pulse,
  input  logic                  fifth_pulse,
  input  logic [4:0]            fifth_num,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  int_n
);
  localparam int AW = ADDR_BITS;
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic {L_FIRST, L_SECOND} latch_e;
  // Operations that touch the VRAM port or the address; these are the ones
  // that can be deferred behind an outstanding request.
  typedef enum logic [1:0] {OP_DWR, OP_DRD, OP_ASW, OP_ASR} op_e;

  latch_e          latch;
  logic            acc, acc_q, act;
  logic [7:0]      first_byte, rbuf;
  logic [7:0]      reg_q [NUM_REGS];
  logic [AW-1:0]   addr, set_addr;
  logic            f_flag, s5_flag, c_flag, clr_pend, stat_clr;
  logic [4:0]      fifth_field;
  logic            pend_vld;
  op_e             pend_op;
  logic [7:0]      pend_din;
  logic            a_need, ex_vld, store_new;
  op_e             a_op, ex_op;
  logic [7:0]      ex_din;

  // Edge detect on the enabled strobe; holding a strobe over several
  // enables produces only one action.
  assign acc = clk_en & (io_rd | io_wr);
  assign act = acc & ~acc_q;

  assign cpu_dout = port_sel ? {f_flag, s5_flag, c_flag, fifth_field} : rbuf;

  // Status flags clear on the first enabled cycle after the read strobe drops.
  assign stat_clr = clr_pend & clk_en & ~io_rd;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[8*g +: 8] = reg_q[g];
  end

  // Address-setup value; wide parts take their top bits from HI_REG.
  if (AW > 14) begin : g_hi
    assign set_addr = {reg_q[HI_REG][AW-15:0], ex_din[5:0], first_byte};
  end else begin : g_lo
    assign set_addr = {ex_din[5:0], first_byte};
  end

  // Which new access needs the VRAM sequencer.
  always_comb begin
    a_need = 1'b0;
    a_op   = OP_DWR;
    if (act) begin
      if (!port_sel) begin
        a_need = 1'b1;
        a_op   = io_wr ? OP_DWR : OP_DRD;
      end else if (io_wr && latch == L_SECOND && !cpu_din[7]) begin
        a_need = 1'b1;
        a_op   = cpu_din[6] ? OP_ASW : OP_ASR;
      end
    end
  end

  // A deferred access runs first once the port is free; a new access that
  // finds the port busy (or a deferred one ahead of it) is parked instead.
  always_comb begin
    ex_vld    = 1'b0;
    ex_op     = pend_op;
    ex_din    = pend_din;
    store_new = a_need & (vram_req | pend_vld);
    if (!vram_req) begin
      if (pend_vld) begin
        ex_vld = 1'b1;
      end else if (a_need) begin
        ex_vld = 1'b1;
        ex_op  = a_op;
        ex_din = cpu_din;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= 1'b0;
      latch       <= L_FIRST;
      first_byte  <= 8'h00;
      rbuf        <= 8'h00;
      addr        <= '0;
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= 8'h00;
      f_flag      <= 1'b0;
      s5_flag     <= 1'b0;
      c_flag      <= 1'b0;
      fifth_field <= 5'd0;
      clr_pend    <= 1'b0;
      int_n       <= 1'b1;
      vram_req    <= 1'b0;
      vram_we     <= 1'b0;
      vram_addr   <= '0;
      vram_wdata  <= 8'h00;
      wait_n      <= 1'b1;
      pend_vld    <= 1'b0;
      pend_op     <= OP_DWR;
      pend_din    <= 8'h00;
    end else begin
      if (clk_en) acc_q <= acc;

      if (stat_clr) clr_pend <= 1'b0;
      // Set pulses win over a coinciding clear.
      f_flag  <= (f_flag & ~stat_clr) | frame_pulse;
      c_flag  <= (c_flag & ~stat_clr) | coll_pulse;
      s5_flag <= (s5_flag & ~stat_clr) | (fifth_pulse & ~f_flag & ~s5_flag);
      if (fifth_pulse && !s5_flag) fifth_field <= fifth_num;
      int_n <= ~(f_flag & reg_q[1][5]);

      if (act) begin
        if (port_sel && io_wr) begin
          if (latch == L_FIRST) begin
            first_byte <= cpu_din;
            latch      <= L_SECOND;
          end else begin
            latch <= L_FIRST;
            if (cpu_din[7])
              for (int i = 0; i < NUM_REGS; i++)
                if (cpu_din[5:0] == 6'(i)) reg_q[i] <= first_byte;
          end
        end else begin
          latch <= L_FIRST;
          if (port_sel) clr_pend <= 1'b1;
        end
      end

      if (vram_req && vram_ack) begin
        vram_req <= 1'b0;
        if (!vram_we) rbuf <= vram_rdata;
      end

      if (ex_vld) begin
        pend_vld <= 1'b0;
        wait_n   <= 1'b1;
        case (ex_op)
          OP_DWR: begin
            vram_req   <= 1'b1;
            vram_we    <= 1'b1;
            vram_addr  <= addr;
            vram_wdata <= ex_din;
            rbuf       <= ex_din;
            addr       <= addr + ADDR_ONE;
          end
          OP_DRD: begin
            vram_req  <= 1'b1;
            vram_we   <= 1'b0;
            vram_addr <= addr;
            addr      <= addr + ADDR_ONE;
          end
          OP_ASW: addr <= set_addr;
          default: begin
            vram_req  <= 1'b1;
            vram_we   <= 1'b0;
            vram_addr <= set_addr;
            addr      <= set_addr + ADDR_ONE;
          end
        endcase
      end

      if (store_new) begin
        pend_vld <= 1'b1;
        pend_op  <= a_op;
        pend_din <= cpu_din;
        wait_n   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb_vdp_cpu_port: scoreboard bench for vdp_cpu_port. It builds two
// instances: a 14-bit one with 8 registers and a 17-bit one with 16
// registers, whose HI_REG is 14. Each instance has a VRAM model with a
// programmable ack latency. Expected VRAM transactions are queued as
// accesses are driven and are retired against the ack.
module tb_vdp_cpu_port;
  logic clk = 1'b0, reset_n = 1'b0, clk_en = 1'b1, port_sel = 1'b0;
  logic [7:0] cpu_din = 8'h00;
  logic rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic frame_pulse = 1'b0, coll_pulse = 1'b0, fifth_pulse = 1'b0;
  logic [4:0] fifth_num = 5'd0;

  logic [7:0]   dout0, wdata0, rdata0 = 8'h00;
  logic [13:0]  addr0;
  logic         wait0, req0, we0, int0, ack0 = 1'b0;
  logic [63:0]  regs0;
  logic [7:0]   dout1, wdata1, rdata1 = 8'h00;
  logic [16:0]  addr1;
  logic         wait1, req1, we1, int1, ack1 = 1'b0;
  logic [127:0] regs1;

  vdp_cpu_port u0 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .io_rd(rd0), .io_wr(wr0),
    .port_sel(port_sel), .cpu_din(cpu_din), .cpu_dout(dout0), .wait_n(wait0),
    .vram_addr(addr0), .vram_wdata(wdata0), .vram_req(req0), .vram_we(we0),
    .vram_rdata(rdata0), .vram_ack(ack0), .frame_pulse(frame_pulse),
    .coll_pulse(coll_pulse), .fifth_pulse(fifth_pulse), .fifth_num(fifth_num),
    .regs(regs0), .int_n(int0));

  vdp_cpu_port #(.ADDR_BITS(17), .NUM_REGS(16), .HI_REG(14)) u1 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .io_rd(rd1), .io_wr(wr1),
    .port_sel(port_sel), .cpu_din(cpu_din), .cpu_dout(dout1), .wait_n(wait1),
    .vram_addr(addr1), .vram_wdata(wdata1), .vram_req(req1), .vram_we(we1),
    .vram_rdata(rdata1), .vram_ack(ack1), .frame_pulse(frame_pulse),
    .coll_pulse(coll_pulse), .fifth_pulse(fifth_pulse), .fifth_num(fifth_num),
    .regs(regs1), .int_n(int1));

  always #5 clk = ~clk;

  typedef struct packed {logic we; logic [16:0] addr; logic [7:0] data;} txn_t;
  txn_t q0[$], q1[$];
  int checks = 0, errors = 0;
  int lat0 = 1, lat1 = 1, cnt0 = 0, cnt1 = 0, ntx1 = 0;
  logic [7:0] mem0 [0:16383];
  logic [7:0] mem1 [0:131071];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // VRAM models: ack after lat cycles, retire against the scoreboard.
  always @(posedge clk) begin
    txn_t e;
    if (!reset_n) begin
      ack0 <= 1'b0; cnt0 = 0;
    end else if (req0 && ack0) begin
      ack0 <= 1'b0; cnt0 = 0;
      chk("vram0_expected", 128'(q0.size() != 0), 128'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("vram0_we", 128'(we0), 128'(e.we));
        chk("vram0_addr", 128'(addr0), 128'(e.addr));
        if (e.we) chk("vram0_wdata", 128'(wdata0), 128'(e.data));
      end
      if (we0) mem0[addr0] <= wdata0;
    end else if (req0) begin
      if (cnt0 >= lat0) begin ack0 <= 1'b1; rdata0 <= mem0[addr0]; end
      else cnt0++;
    end else cnt0 = 0;
  end

  always @(posedge clk) begin
    txn_t e;
    if (!reset_n) begin
      ack1 <= 1'b0; cnt1 = 0;
    end else if (req1 && ack1) begin
      ack1 <= 1'b0; cnt1 = 0; ntx1++;
      chk("vram1_expected", 128'(q1.size() != 0), 128'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("vram1_we", 128'(we1), 128'(e.we));
        chk("vram1_addr", 128'(addr1), 128'(e.addr));
        if (e.we) chk("vram1_wdata", 128'(wdata1), 128'(e.data));
      end
      if (we1) mem1[addr1] <= wdata1;
    end else if (req1) begin
      if (cnt1 >= lat1) begin ack1 <= 1'b1; rdata1 <= mem1[addr1]; end
      else cnt1++;
    end else cnt1 = 0;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic access(input int u, input logic port, input logic wr,
                        input logic [7:0] din, output logic [7:0] dout);
    @(negedge clk);
    port_sel = port; cpu_din = din;
    if (u == 0) begin rd0 = ~wr; wr0 = wr; end
    else        begin rd1 = ~wr; wr1 = wr; end
    @(negedge clk);
    dout = (u == 0) ? dout0 : dout1;
    @(negedge clk);
    rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
  endtask

  task automatic ctrl_wr(input int u, input logic [7:0] d);
    logic [7:0] x;
    access(u, 1'b1, 1'b1, d, x);
  endtask

  task automatic data_wr(input int u, input logic [7:0] d);
    logic [7:0] x;
    access(u, 1'b0, 1'b1, d, x);
  endtask

  task automatic data_rd(input int u, output logic [7:0] d);
    access(u, 1'b0, 1'b0, 8'h00, d);
  endtask

  // Status read on instance 0; optionally fires frame_pulse on the clear cycle.
  task automatic stat_rd(input logic pulse, output logic [7:0] d);
    @(negedge clk); port_sel = 1'b1; rd0 = 1'b1;
    @(negedge clk); d = dout0;
    @(negedge clk); rd0 = 1'b0; frame_pulse = pulse;
    @(negedge clk); frame_pulse = 1'b0;
  endtask

  task automatic drain(input int u);
    int k = 0;
    while (((u == 0) ? (q0.size() != 0 || req0) : (q1.size() != 0 || req1)) && k < 200) begin
      @(negedge clk); k++;
    end
    chk("drain_in_time", 128'(k < 200), 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int k;
    for (int i = 0; i < 16384; i++) mem0[i] = 8'h00;
    for (int i = 0; i < 131072; i++) mem1[i] = 8'h00;
    mem0[14'h1234] = 8'hAA;
    mem0[14'h1235] = 8'hBB;

    // Reset state
    idle(3);
    chk("rst_req0", 128'(req0), 128'd0);
    chk("rst_wait0", 128'(wait0), 128'd1);
    chk("rst_int0", 128'(int0), 128'd1);
    chk("rst_dout0", 128'(dout0), 128'd0);
    chk("rst_regs0", 128'(regs0), 128'd0);
    chk("rst_regs1", regs1, 128'd0);
    reset_n = 1'b1;
    idle(2);

    // Register writes; out-of-range index ignored
    ctrl_wr(0, 8'hE2); ctrl_wr(0, 8'h81); idle(2);
    chk("reg1_write", 128'(regs0[15:8]), 128'hE2);
    chk("int_idle", 128'(int0), 128'd1);
    ctrl_wr(0, 8'h55); ctrl_wr(0, 8'h9F); idle(2);
    chk("reg_oob_ignored", 128'(regs0), 128'h0000_0000_0000_E200);

    // Address setup with read-ahead
    ctrl_wr(0, 8'h34);
    q0.push_back('{1'b0, 17'h01234, 8'h00});
    ctrl_wr(0, 8'h12);
    chk("prefetch_req", 128'(req0), 128'd1);
    chk("prefetch_addr", 128'(addr0), 128'h1234);
    drain(0);
    q0.push_back('{1'b0, 17'h01235, 8'h00});
    data_rd(0, d); chk("rd_first", 128'(d), 128'hAA);
    drain(0);
    q0.push_back('{1'b0, 17'h01236, 8'h00});
    data_rd(0, d); chk("rd_second", 128'(d), 128'hBB);
    drain(0);

    // Write-mode setup at 0x3FFF and wrap to 0x0000
    ctrl_wr(0, 8'hFF); ctrl_wr(0, 8'h7F); idle(2);
    chk("wsetup_no_req", 128'(req0), 128'd0);
    q0.push_back('{1'b1, 17'h03FFF, 8'h11});
    data_wr(0, 8'h11); drain(0);
    q0.push_back('{1'b1, 17'h00000, 8'h22});
    data_wr(0, 8'h22); drain(0);
    chk("mem_3fff", 128'(mem0[14'h3FFF]), 128'h11);
    chk("mem_0000", 128'(mem0[14'h0000]), 128'h22);
    q0.push_back('{1'b0, 17'h00001, 8'h00});
    data_rd(0, d); chk("rd_after_wr_buf", 128'(d), 128'h22);
    drain(0);

    // Status, interrupt and clear-on-read
    ctrl_wr(0, 8'h20); ctrl_wr(0, 8'h81); idle(2);
    chk("reg1_int_en", 128'(regs0[15:8]), 128'h20);
    @(negedge clk); frame_pulse = 1'b1;
    @(negedge clk); frame_pulse = 1'b0;
    chk("int_latency", 128'(int0), 128'd1);
    @(negedge clk);
    chk("int_asserted", 128'(int0), 128'd0);
    stat_rd(1'b0, d); chk("stat_f_set", 128'(d), 128'h80);
    idle(2);
    chk("int_cleared", 128'(int0), 128'd1);
    stat_rd(1'b0, d); chk("stat_f_clear", 128'(d), 128'h00);
    @(negedge clk); frame_pulse = 1'b1;
    @(negedge clk); frame_pulse = 1'b0;
    idle(2);
    stat_rd(1'b1, d); chk("stat_f_again", 128'(d), 128'h80);
    idle(1);
    stat_rd(1'b0, d); chk("stat_set_wins", 128'(d), 128'h80);
    idle(1);
    stat_rd(1'b0, d); chk("stat_cleared2", 128'(d), 128'h00);
    @(negedge clk); coll_pulse = 1'b1; fifth_pulse = 1'b1; fifth_num = 5'd7;
    @(negedge clk); coll_pulse = 1'b0; fifth_pulse = 1'b0;
    idle(1);
    stat_rd(1'b0, d); chk("stat_c_5s", 128'(d), 128'h67);
    idle(1);
    stat_rd(1'b0, d); chk("stat_5s_clear", 128'(d), 128'h07);

    // Busy conflict and wait
    lat0 = 10;
    ctrl_wr(0, 8'h00); ctrl_wr(0, 8'h41);
    q0.push_back('{1'b1, 17'h00100, 8'hA1});
    data_wr(0, 8'hA1);
    q0.push_back('{1'b1, 17'h00101, 8'hB2});
    data_wr(0, 8'hB2);
    chk("wait_low", 128'(wait0), 128'd0);
    chk("hold_req", 128'(req0), 128'd1);
    chk("hold_addr", 128'(addr0), 128'h100);
    idle(3);
    chk("wait_still_low", 128'(wait0), 128'd0);
    chk("stable_addr", 128'(addr0), 128'h100);
    chk("stable_wdata", 128'(wdata0), 128'hA1);
    chk("stable_we", 128'(we0), 128'd1);
    k = 0;
    while (!wait0 && k < 100) begin @(negedge clk); k++; end
    chk("wait_release", 128'(wait0), 128'd1);
    chk("first_acked", 128'(q0.size()), 128'd1);
    chk("second_req", 128'(req0), 128'd1);
    chk("second_addr", 128'(addr0), 128'h101);
    chk("second_wdata", 128'(wdata0), 128'hB2);
    lat0 = 1;
    drain(0);

    // 17-bit instance: HI_REG address bits, strobe held over 5 enables
    ctrl_wr(1, 8'h05); ctrl_wr(1, 8'h8E); idle(2);
    chk("reg14_write", 128'(regs1[119:112]), 128'h05);
    ctrl_wr(1, 8'h20); ctrl_wr(1, 8'h43);
    q1.push_back('{1'b1, 17'h14320, 8'h5A});
    @(negedge clk); port_sel = 1'b0; cpu_din = 8'h5A; wr1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clk_en = (i % 2 == 0);
      @(negedge clk);
    end
    wr1 = 1'b0; clk_en = 1'b1;
    drain(1); idle(5);
    chk("held_strobe_one_write", 128'(ntx1), 128'd1);
    chk("mem1_14320", 128'(mem1[17'h14320]), 128'h5A);

    // Reset with a request outstanding and another pending
    lat1 = 50;
    data_wr(1, 8'hC3);
    data_wr(1, 8'hD4);
    chk("abort_req_out", 128'(req1), 128'd1);
    chk("abort_wait_low", 128'(wait1), 128'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_req_drop", 128'(req1), 128'd0);
    chk("abort_wait_high", 128'(wait1), 128'd1);
    chk("abort_regs1", regs1, 128'd0);
    chk("abort_regs0", 128'(regs0), 128'd0);
    chk("abort_int1", 128'(int1), 128'd1);
    idle(2);
    reset_n = 1'b1; lat1 = 1;
    idle(10);
    chk("abort_no_stray", 128'(ntx1), 128'd1);
    chk("abort_req_idle", 128'(req1), 128'd0);
    chk("sb0_empty", 128'(q0.size()), 128'd0);
    chk("sb1_empty", 128'(q1.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
